// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: locks to hsync/vsync timing, rebuilds pixel coordinates,
// checks line/frame lengths and captures a probe pixel. Define VGA_RX_CRC_EN for a per-frame CRC-16.
module vga_rx_monitor #(
   parameter int H_TOTAL   = 800,
   parameter int V_TOTAL   = 525,
   parameter int H_ACT_OFS = 144,
   parameter int V_ACT_OFS = 35,
   parameter int H_DISP    = 640,
   parameter int V_DISP    = 480,
   parameter bit SYNC_POL  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [11:0] rgb_in,
   input  logic [9:0]  probe_x,
   input  logic [9:0]  probe_y,
   input  logic        err_clr,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        video_on,
   output logic        locked,
   output logic        frame_tick,
   output logic [7:0]  frame_count,
   output logic [11:0] probe_rgb,
   output logic        probe_valid,
   output logic        err_hlen,
   output logic        err_vlen,
   output logic [15:0] frame_crc
);

   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
   localparam logic [10:0] H_OFS   = 11'(H_ACT_OFS);
   localparam logic [10:0] V_OFS   = 11'(V_ACT_OFS);
   localparam logic [10:0] H_END   = 11'(H_ACT_OFS + H_DISP);
   localparam logic [10:0] V_END   = 11'(V_ACT_OFS + V_DISP);
   localparam logic [10:0] CNT_MAX = 11'h7FF;

   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
   state_t state, state_nxt;

   logic        good, good_nxt, seen_h;
   logic        hs_prev, vs_prev;
   logic [10:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
   logic        hs_on, vs_on, hs_edge, vs_edge;
   logic        h_fail, v_fail, lock_fail, frame_ok, active;
   logic [9:0]  x_pos, y_pos;

   // hs_prev/vs_prev hold "was asserted", so a stream already inside a pulse
   // at reset release cannot produce a false leading edge.
   always_comb begin
      hs_on   = (hsync == SYNC_POL);
      vs_on   = (vsync == SYNC_POL);
      hs_edge = p_tick && hs_on && !hs_prev;
      vs_edge = p_tick && vs_on && !vs_prev;
      h_fail  = hs_edge && seen_h && (hcnt != H_LAST);
      v_fail  = vs_edge && (vcnt != V_LEN);

      hcnt_nxt = hs_edge ? 11'd0 : ((hcnt == CNT_MAX) ? hcnt : hcnt + 11'd1);
      if (vs_edge)
         vcnt_nxt = {10'd0, hs_edge};
      else if (hs_edge)
         vcnt_nxt = (vcnt == CNT_MAX) ? vcnt : vcnt + 11'd1;
      else
         vcnt_nxt = vcnt;

      x_pos  = 10'(hcnt_nxt - H_OFS);
      y_pos  = 10'(vcnt_nxt - V_OFS);
      active = (hcnt_nxt >= H_OFS) && (hcnt_nxt < H_END) &&
               (vcnt_nxt >= V_OFS) && (vcnt_nxt < V_END);
   end

   always_comb begin
      state_nxt = state;
      good_nxt  = good;
      lock_fail = 1'b0;
      frame_ok  = 1'b0;
      case (state)
         SEARCH: if (vs_edge) begin
            state_nxt = ALIGN;
            good_nxt  = 1'b1;
         end
         ALIGN: begin
            if (h_fail) good_nxt = 1'b0;
            if (vs_edge) begin
               if (good && !h_fail && !v_fail) state_nxt = LOCKED;
               good_nxt = 1'b1;
            end
         end
         LOCKED: begin
            if (h_fail || v_fail) begin
               state_nxt = SEARCH;
               lock_fail = 1'b1;
            end else if (vs_edge) begin
               frame_ok = 1'b1;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SEARCH;
         good  <= 1'b0;
      end else begin
         state <= state_nxt;
         good  <= good_nxt;
      end
   end

   assign locked = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_prev     <= 1'b1;
         vs_prev     <= 1'b1;
         hcnt        <= '0;
         vcnt        <= '0;
         seen_h      <= 1'b0;
         x           <= '0;
         y           <= '0;
         video_on    <= 1'b0;
         frame_tick  <= 1'b0;
         frame_count <= '0;
         probe_rgb   <= '0;
         probe_valid <= 1'b0;
         err_hlen    <= 1'b0;
         err_vlen    <= 1'b0;
      end else begin
         frame_tick  <= 1'b0;
         probe_valid <= 1'b0;
         // A failure in the same cycle as err_clr keeps the flag set.
         if (err_clr) begin
            err_hlen <= 1'b0;
            err_vlen <= 1'b0;
         end
         if (lock_fail && h_fail) err_hlen <= 1'b1;
         if (lock_fail && v_fail) err_vlen <= 1'b1;
         if (p_tick) begin
            hs_prev  <= hs_on;
            vs_prev  <= vs_on;
            hcnt     <= hcnt_nxt;
            vcnt     <= vcnt_nxt;
            video_on <= locked && active;
            if (hs_edge) seen_h <= 1'b1;
            if (active) begin
               x <= x_pos;
               y <= y_pos;
            end
            if (locked && active && x_pos == probe_x && y_pos == probe_y) begin
               probe_rgb   <= rgb_in;
               probe_valid <= 1'b1;
            end
            if (frame_ok) begin
               frame_tick  <= 1'b1;
               frame_count <= frame_count + 8'd1;
            end
         end
      end
   end

`ifdef VGA_RX_CRC_EN
   // CRC-16-CCITT, 12 data bits per pixel, MSB first.
   function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 11; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   logic [15:0] crc_acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         crc_acc   <= 16'hFFFF;
         frame_crc <= 16'h0000;
      end else if (p_tick) begin
         if (vs_edge) begin
            crc_acc <= 16'hFFFF;
            if (frame_ok) frame_crc <= crc_acc;
         end else if (active) begin
            crc_acc <= crc12(crc_acc, rgb_in);
         end
      end
   end
`else
   assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Randomized scoreboard bench for vga_rx_monitor on a reduced 32x20 raster.
module tb_vga_rx_monitor;
   localparam int HT = 32, HS = 22, HE = 26, HD = 20;
   localparam int VT = 20, VS = 14, VE = 16, VD = 12;

   logic        clk, reset, p_tick, hsync, vsync, err_clr;
   logic [11:0] rgb_in;
   logic [9:0]  probe_x, probe_y, x, y;
   logic        video_on, locked, frame_tick, probe_valid, err_hlen, err_vlen;
   logic [7:0]  frame_count;
   logic [11:0] probe_rgb;
   logic [15:0] frame_crc;

   vga_rx_monitor #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_OFS(HT - HS), .V_ACT_OFS(VT - VS),
      .H_DISP(HD), .V_DISP(VD), .SYNC_POL(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
      .rgb_in(rgb_in), .probe_x(probe_x), .probe_y(probe_y), .err_clr(err_clr),
      .x(x), .y(y), .video_on(video_on), .locked(locked), .frame_tick(frame_tick),
      .frame_count(frame_count), .probe_rgb(probe_rgb), .probe_valid(probe_valid),
      .err_hlen(err_hlen), .err_vlen(err_vlen), .frame_crc(frame_crc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0, bad = 0;

   typedef struct { logic [7:0] cnt; logic [15:0] crc; } ft_t;
   logic [11:0] pq[$];
   ft_t         fq[$];
   logic [11:0] mon_p;
   ft_t         mon_f;

   // reference model state: geometry comes from the generator's line/pixel indices
   int          m_mode, m_good, m_seen, m_ht, m_lines;
   logic [7:0]  m_fc;
   logic        m_eh, m_ev;
   logic [15:0] m_crc, m_crc_last;
   int          pat_mode, gap_mode, vo_cnt, vo_exp;
   logic        clr_arm;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 11; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (probe_valid) begin
         if (pq.size() == 0) begin
            total++; bad++;
            $display("FAIL probe_unexpected: got rgb 0x%0h expected no capture", probe_rgb);
         end else begin
            mon_p = pq.pop_front();
            chk("probe_rgb", 32'(probe_rgb), 32'(mon_p));
         end
      end
      if (frame_tick) begin
         if (fq.size() == 0) begin
            total++; bad++;
            $display("FAIL frame_tick_unexpected: got count %0d expected no tick", frame_count);
         end else begin
            mon_f = fq.pop_front();
            chk("frame_count", 32'(frame_count), 32'(mon_f.cnt));
            chk("frame_crc", 32'(frame_crc), 32'(mon_f.crc));
         end
      end
   end

   task automatic model_reset();
      m_mode = 0; m_good = 0; m_seen = 0; m_ht = 0; m_lines = 0;
      m_fc = 8'd0; m_eh = 1'b0; m_ev = 1'b0; m_crc = 16'hFFFF; m_crc_last = 16'h0;
   endtask

   task automatic do_reset();
      p_tick = 1'b0; reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_x", 32'(x), 0);                 chk("rst_y", 32'(y), 0);
      chk("rst_video_on", 32'(video_on), 0);   chk("rst_locked", 32'(locked), 0);
      chk("rst_frame_tick", 32'(frame_tick), 0);
      chk("rst_frame_count", 32'(frame_count), 0);
      chk("rst_probe_rgb", 32'(probe_rgb), 0); chk("rst_probe_valid", 32'(probe_valid), 0);
      chk("rst_err_hlen", 32'(err_hlen), 0);   chk("rst_err_vlen", 32'(err_vlen), 0);
      chk("rst_frame_crc", 32'(frame_crc), 0);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_tick(input int line, input int h);
      logic        hs, vs, act, hedge, vedge, hfail, vfail, fok, exp_vo, clr;
      logic [11:0] c;
      int          gap;
      ft_t         f;
      hs  = (h >= HS) && (h < HE);
      vs  = (line >= VS) && (line < VE);
      act = (line < VD) && (h < HD);
      case (pat_mode)
         0:       c = 12'($urandom);
         1:       c = {4'(h), 4'(line), 4'hA};
         default: c = 12'h000;
      endcase
      hedge = (h == HS);
      vedge = (line == VS) && (h == 0);
      m_ht++;
      hfail = hedge && (m_seen != 0) && (m_ht != HT);
      if (hedge) begin m_ht = 0; m_seen = 1; end
      vfail = vedge && (m_lines != VT);
      if (vedge) m_lines = 0;
      if (hedge) m_lines++;
      clr = clr_arm && vedge;
      if (clr) begin m_eh = 1'b0; m_ev = 1'b0; end
      fok = 1'b0;
      if (m_mode == 2 && act && h == int'(probe_x) && line == int'(probe_y)) pq.push_back(c);
      case (m_mode)
         0: if (vedge) begin m_mode = 1; m_good = 1; end
         1: begin
            if (hfail) m_good = 0;
            if (vedge) begin
               if (m_good != 0 && !vfail) m_mode = 2;
               m_good = 1;
            end
         end
         default: begin
            if (hfail || vfail) begin
               m_mode = 0;
               if (hfail) m_eh = 1'b1;
               if (vfail) m_ev = 1'b1;
            end else if (vedge) fok = 1'b1;
         end
      endcase
      if (vedge) begin
         if (fok) m_crc_last = m_crc;
         m_crc = 16'hFFFF;
      end else if (act) m_crc = crc12(m_crc, c);
      if (fok) begin
         m_fc++;
         f.cnt = m_fc;
`ifdef VGA_RX_CRC_EN
         f.crc = m_crc_last;
`else
         f.crc = 16'h0000;
`endif
         fq.push_back(f);
      end
      exp_vo = (m_mode == 2) && act;
      if (exp_vo) vo_exp++;

      hsync = hs; vsync = vs; rgb_in = c; err_clr = clr; p_tick = 1'b1;
      @(negedge clk);
      p_tick = 1'b0; err_clr = 1'b0;
      if (video_on) vo_cnt++;
      if (hedge || vedge) begin
         chk("locked", 32'(locked), 32'(m_mode == 2));
         chk("err_hlen", 32'(err_hlen), 32'(m_eh));
         chk("err_vlen", 32'(err_vlen), 32'(m_ev));
      end
      if (h == 0 || h == HD - 1 || h == HD || h == HT - 1)
         chk("video_on", 32'(video_on), 32'(exp_vo));
      if (m_mode == 2 && act && (h == 0 || h == HD - 1) && (line == 0 || line == 5 || line == VD - 1)) begin
         chk("x", 32'(x), 32'(h));
         chk("y", 32'(y), 32'(line));
      end
      if (m_mode == 2 && line < VD && h == HD) chk("x_hold", 32'(x), 32'(HD - 1));
      gap = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
      repeat (gap) @(negedge clk);
   endtask

   // kind: 0 clean, 1 one 31-tick line, 2 one line missing, 3 reset mid-frame
   task automatic run_frame(input int kind);
      for (int l = 0; l < VT; l++) begin
         if (kind == 2 && l == 12) continue;
         for (int h = 0; h < HT; h++) begin
            if (kind == 1 && l == 12 && h == HS + 1) continue;
            if (kind == 3 && l == 5 && h == 7) do_reset();
            do_tick(l, h);
         end
      end
      @(negedge clk); #1;
      chk("probe_pending", 32'(pq.size()), 0);
      chk("frame_pending", 32'(fq.size()), 0);
      chk("video_on_ticks", 32'(vo_cnt), 32'(vo_exp));
      vo_cnt = 0; vo_exp = 0;
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_eh = 1'b0; m_ev = 1'b0;
      chk("clr_err_hlen", 32'(err_hlen), 0);
      chk("clr_err_vlen", 32'(err_vlen), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0; err_clr = 1'b0;
      rgb_in = 12'h0; probe_x = 10'd5; probe_y = 10'd3; clr_arm = 1'b0;
      vo_cnt = 0; vo_exp = 0;
      @(negedge clk);
      do_reset();

      // clean stream, pixel = {x,y,A}, probe at (5,3)
      gap_mode = 3; pat_mode = 1;
      repeat (3) run_frame(0);

      // random pixels, random probe points, gapped p_tick
      gap_mode = -1; pat_mode = 0;
      repeat (2) begin
         probe_x = 10'($urandom_range(0, HD - 1));
         probe_y = 10'($urandom_range(0, VD - 1));
         run_frame(0);
      end

      run_frame(1);
      repeat (2) run_frame(0);
      clear_err();

      // missing line; err_clr coincides with the failing vsync edge
      clr_arm = 1'b1;
      run_frame(2);
      clr_arm = 1'b0;
      repeat (3) run_frame(0);
      clear_err();

      run_frame(3);
      repeat (2) run_frame(0);

      // all-zero active frames, one with the probe outside the active range
      pat_mode = 2;
      probe_x = 10'd700;
      run_frame(0);
      probe_x = 10'd0; probe_y = 10'(VD - 1);
      run_frame(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vga_rx_monitor.md
# vga_rx_monitor

Receive-side monitor for the 640x480 VGA stream produced by the game top. It samples hsync/vsync/rgb on the pixel enable and locks to the sync timing. Once locked, it reconstructs pixel coordinates, checks line and frame lengths, and captures one probe pixel per frame. It sits in simulation benches and on-board debug taps downstream of the VGA controller and RGB register.

## Interface
Parameters:
- H_TOTAL, 800: pixel ticks per line, hsync leading edge to leading edge.
- V_TOTAL, 525: hsync leading edges per frame, vsync leading edge to leading edge.
- H_ACT_OFS, 144: hcnt value of the first active pixel.
- V_ACT_OFS, 35: vcnt value of the first active line.
- H_DISP, 640: active pixels per line.
- V_DISP, 480: active lines per frame.
- SYNC_POL, 1: asserted level of hsync/vsync pulses.

Ports:
- clk  in  1  system clock, same domain as the VGA controller.
- reset  in  1  synchronous, active-high.
- p_tick  in  1  pixel enable; all sampling is gated by it.
- hsync  in  1  horizontal sync.
- vsync  in  1  vertical sync.
- rgb_in  in  12  pixel colour.
- probe_x  in  10  probe column.
- probe_y  in  10  probe row.
- err_clr  in  1  clears err_hlen/err_vlen.
- x  out  10  active column.
- y  out  10  active row.
- video_on  out  1  locked and in active area.
- locked  out  1  FSM in LOCKED.
- frame_tick  out  1  one-clk pulse per vsync leading edge while locked.
- frame_count  out  8  locked frames, wraps 255→0.
- probe_rgb  out  12  captured probe pixel.
- probe_valid  out  1  one-clk pulse on capture.
- err_hlen  out  1  sticky bad line length.
- err_vlen  out  1  sticky bad frame length.
- frame_crc  out  16  CRC of last locked frame (see Configuration).

## Operation
- On p_tick, register hs/vs samples and their previous values. Leading edge = current asserted (==SYNC_POL) and previous deasserted.
- hcnt (11b): cleared to 0 on an hsync leading edge, otherwise +1. Saturates at 2047.
- vcnt (11b): cleared on a vsync leading edge, +1 on each hsync leading edge. Saturates at 2047. Both edges on the same tick → vcnt=1.
- Active area: hcnt−H_ACT_OFS in [0,H_DISP) and vcnt−V_ACT_OFS in [0,V_DISP). x/y are those differences; otherwise x/y hold their last values.
- Line check, at each hsync leading edge after the first since reset: hcnt must equal H_TOTAL−1.
- Frame check, at each vsync leading edge: vcnt must equal V_TOTAL, evaluated before the clear.
- Lock FSM:
  - SEARCH (reset state): on a vsync edge → ALIGN, and set good=1.
  - ALIGN: a failed line check sets good=0. At the next vsync edge: if good and the frame check passes → LOCKED; else stay in ALIGN with good=1.
  - LOCKED: any failed check → SEARCH and set the matching sticky error. Simultaneous failures set both.
- Errors are flagged only from LOCKED. err_clr clears them; a failure in the same cycle as err_clr wins (flag stays set).
- Probe: on a p_tick while LOCKED, in active area, with x==probe_x and y==probe_y (combinational position for this tick) → probe_rgb<=rgb_in, probe_valid pulses. probe_x/probe_y outside the active range mean no capture.
- frame_count increments with frame_tick.

## Timing
- Reset values: x=y=0, video_on=0, locked=0, frame_tick=0, frame_count=0, probe_rgb=0, probe_valid=0, err_hlen=err_vlen=0, frame_crc=0. Internal: hcnt=vcnt=0, FSM=SEARCH, first-line flag cleared.
- Reset mid-stream returns to SEARCH, and lock is re-acquired by the same sequence as after power-up.
- Latency: x, y, video_on, probe_* and frame_tick update on the clk edge ending the p_tick cycle in which the sample was taken, i.e. 1 clk after that sample.
- Clean stream: locked rises 1 clk after the second vsync leading edge following reset, about one frame.
- Without p_tick all state holds. frame_tick, probe_valid, frame_count and frame_crc behave as specified whether p_tick is continuous or gapped.

## Configuration
- VGA_RX_CRC_EN defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) over the 12-bit rgb_in of every active pixel, MSB first.
  - Accumulator re-inits at each vsync edge.
  - frame_crc latches the final value at each vsync edge that passes the frame check while LOCKED.
- VGA_RX_CRC_EN undefined: frame_crc tied to 16'h0000, no CRC logic.

## Test plan
- Clean 800x525 stream, vsync at lines 490–491, hsync at h 656–751, p_tick every 4th clk → locked after second vsync edge; (x,y)=(0,0) at line 0 h=0; video_on for exactly 307200 ticks/frame; errors stay 0.
- Locked, pixel pattern rgb={x[3:0],y[3:0],4'hA}, probe (5,3) → probe_valid once per frame, probe_rgb=12'h53A.
- Locked, one 799-tick line injected → err_hlen=1, locked=0 at the next hsync edge; relock within 2 frames; err_clr → err_hlen=0.
- Locked, one 524-line frame → err_vlen=1, locked drops at that vsync edge; frame_count stops until relock.
- Reset asserted mid-frame for 3 clks → all outputs at reset values; relock after two vsync edges; frame_count restarts at 0.
- VGA_RX_CRC_EN, all-zero active frame → frame_crc equals the golden model value, identical every frame; undefined → 0.
